// File: rtl/ita_tile_scheduler_pkg.sv
// Shared types for the tiled-matmul scheduler: FSM states, mask modes and counter type.
package ita_tile_scheduler_pkg;

  localparam int unsigned SchedCw = 16;

  typedef logic [SchedCw-1:0] sched_cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sched_state_e;

  typedef enum logic [1:0] {
    MaskNone  = 2'd0,
    MaskUpper = 2'd1,
    MaskLower = 2'd2,
    MaskRsvd  = 2'd3
  } mask_mode_e;

endpackage

// File: rtl/ita_tile_scheduler_if.sv
// Operand triple handshake plus output FIFO pop handshake seen by the tile scheduler.
interface ita_tile_scheduler_if;

  logic inp_valid;
  logic inp_ready;
  logic weight_valid;
  logic weight_ready;
  logic bias_valid;
  logic bias_ready;
  logic oup_valid;
  logic oup_ready;

  modport master (
    output inp_valid, weight_valid, bias_valid, oup_valid, oup_ready,
    input  inp_ready, weight_ready, bias_ready
  );

  modport slave (
    input  inp_valid, weight_valid, bias_valid, oup_valid, oup_ready,
    output inp_ready, weight_ready, bias_ready
  );

endinterface

// File: rtl/ita_tile_scheduler_lane_mask.sv
// Combinational per-lane validity: ragged row/col padding plus triangular attention masks.
module ita_tile_scheduler_lane_mask
  import ita_tile_scheduler_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = 16
) (
  input  logic          en_i,
  input  logic [CW:0]   row_i,
  input  logic [CW:0]   col_base_i,
  input  logic [CW-1:0] rows_i,
  input  logic [CW-1:0] cols_i,
  input  logic [CW-1:0] offset_i,
  input  mask_mode_e    mode_i,
  output logic [N-1:0]  mask_o
);

  // Two spare bits keep row + offset and col_base + k exact.
  localparam int unsigned W = CW + 2;

  logic [W-1:0] w_row;
  logic [W-1:0] w_diag;
  logic         w_row_ok;

  assign w_row    = W'(row_i);
  assign w_diag   = w_row + W'(offset_i);
  assign w_row_ok = w_row < W'(rows_i);

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [W-1:0] w_col;
    logic         w_tri;

    assign w_col = W'(col_base_i) + W'(k);

    always_comb begin
      w_tri = 1'b1;
      case (mode_i)
        MaskUpper: w_tri = (w_col <= w_diag);
        MaskLower: w_tri = (w_col >= w_diag);
        default:   w_tri = 1'b1;
      endcase
    end

    assign mask_o[k] = en_i & w_row_ok & (w_col < W'(cols_i)) & w_tri;
  end

endmodule

// File: rtl/ita_tile_scheduler.sv
// Tile scheduler for one tiled matmul layer: walks beats/inner/tile_x/tile_y loops, applies
// output-FIFO credit backpressure and emits the per-beat lane validity mask.
module ita_tile_scheduler
  import ita_tile_scheduler_pkg::*;
#(
  parameter int unsigned M          = 64,
  parameter int unsigned N          = 16,
  parameter int unsigned CW         = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CW-1:0]        rows_i,
  input  logic [CW-1:0]        cols_i,
  input  logic [CW-1:0]        inner_tiles_i,
  input  logic [1:0]           mask_mode_i,
  input  logic [CW-1:0]        mask_offset_i,
  ita_tile_scheduler_if.slave  op,
  output logic                 calc_en_o,
  output logic                 first_inner_o,
  output logic                 last_inner_o,
  output logic [CW-1:0]        tile_x_o,
  output logic [CW-1:0]        tile_y_o,
  output logic [CW-1:0]        inner_tile_o,
  output logic [N-1:0]         lane_mask_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned Beats = M * M / N;
  localparam int unsigned BeatW = $clog2(Beats);
  localparam int unsigned LogM  = $clog2(M);
  localparam int unsigned LogN  = $clog2(N);
  localparam int unsigned CredW = $clog2(FIFO_DEPTH + 1);

  sched_state_e     r_state;
  mask_mode_e       r_mode;
  logic [CW-1:0]    r_rows, r_cols, r_inner, r_offset, r_tiles_x, r_tiles_y;
  logic [CW-1:0]    r_inner_tile, r_tile_x, r_tile_y;
  logic [BeatW-1:0] r_beat;
  logic [CredW-1:0] r_credits;
  logic             r_done;

  logic          w_run, w_stall, w_go, w_fire, w_push, w_pop;
  logic          w_beat_last, w_inner_last, w_x_last, w_y_last;
  logic [CW-1:0] w_tiles_x, w_tiles_y;
  logic [CW:0]   w_row, w_col_base;

  assign w_run   = (r_state == StRun);
  assign w_stall = (r_credits >= CredW'(FIFO_DEPTH));
  assign w_go    = w_run && !w_stall;
  assign w_fire  = w_go && op.inp_valid && op.weight_valid && op.bias_valid;

  assign op.inp_ready    = w_go && op.weight_valid && op.bias_valid;
  assign op.weight_ready = w_go && op.inp_valid && op.bias_valid;
  assign op.bias_ready   = w_go && op.inp_valid && op.weight_valid;

  assign w_beat_last  = (r_beat == BeatW'(Beats - 1));
  assign w_inner_last = (r_inner_tile == r_inner - CW'(1));
  assign w_x_last     = (r_tile_x == r_tiles_x - CW'(1));
  assign w_y_last     = (r_tile_y == r_tiles_y - CW'(1));

  assign w_push = w_fire && w_inner_last;
  assign w_pop  = op.oup_valid && op.oup_ready && (r_credits != '0);

  assign w_tiles_x = CW'(({1'b0, cols_i} + (CW+1)'(M - 1)) >> LogM);
  assign w_tiles_y = CW'(({1'b0, rows_i} + (CW+1)'(M - 1)) >> LogM);

  // Beat b covers row (b mod M) and lane group (b / M) of the current output tile.
  assign w_row      = ((CW+1)'(r_tile_y) << LogM) + ((CW+1)'(r_beat) & (CW+1)'(M - 1));
  assign w_col_base = ((CW+1)'(r_tile_x) << LogM) + ((CW+1)'(r_beat >> LogM) << LogN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_mode       <= MaskNone;
      r_rows       <= '0;
      r_cols       <= '0;
      r_inner      <= '0;
      r_offset     <= '0;
      r_tiles_x    <= '0;
      r_tiles_y    <= '0;
      r_inner_tile <= '0;
      r_tile_x     <= '0;
      r_tile_y     <= '0;
      r_beat       <= '0;
      r_credits    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_rows       <= rows_i;
            r_cols       <= cols_i;
            r_inner      <= inner_tiles_i;
            r_offset     <= mask_offset_i;
            r_mode       <= mask_mode_e'(mask_mode_i);
            r_tiles_x    <= w_tiles_x;
            r_tiles_y    <= w_tiles_y;
            r_inner_tile <= '0;
            r_tile_x     <= '0;
            r_tile_y     <= '0;
            r_beat       <= '0;
            if (rows_i == '0 || cols_i == '0 || inner_tiles_i == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          if (w_fire) begin
            if (w_beat_last) begin
              r_beat <= '0;
              if (w_inner_last) begin
                r_inner_tile <= '0;
                if (w_x_last) begin
                  r_tile_x <= '0;
                  if (w_y_last) begin
                    r_tile_y <= '0;
                    r_state  <= StDrain;
                  end else begin
                    r_tile_y <= r_tile_y + CW'(1);
                  end
                end else begin
                  r_tile_x <= r_tile_x + CW'(1);
                end
              end else begin
                r_inner_tile <= r_inner_tile + CW'(1);
              end
            end else begin
              r_beat <= r_beat + BeatW'(1);
            end
          end
        end
        StDrain: begin
          if (r_credits == '0) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase

      if (w_push && !w_pop) begin
        r_credits <= r_credits + CredW'(1);
      end else if (w_pop && !w_push) begin
        r_credits <= r_credits - CredW'(1);
      end
    end
  end

  ita_tile_scheduler_lane_mask #(
    .N  (N),
    .CW (CW)
  ) u_lane_mask (
    .en_i       (w_fire),
    .row_i      (w_row),
    .col_base_i (w_col_base),
    .rows_i     (r_rows),
    .cols_i     (r_cols),
    .offset_i   (r_offset),
    .mode_i     (r_mode),
    .mask_o     (lane_mask_o)
  );

  assign calc_en_o     = w_fire;
  assign first_inner_o = w_run && (r_inner_tile == '0);
  assign last_inner_o  = w_run && w_inner_last;
  assign tile_x_o      = r_tile_x;
  assign tile_y_o      = r_tile_y;
  assign inner_tile_o  = r_inner_tile;
  assign busy_o        = (r_state != StIdle);
  assign done_o        = r_done;

endmodule

// File: tb/tb_ita_tile_scheduler.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_ita_tile_scheduler;

  typedef struct packed {
    logic [15:0] tx;
    logic [15:0] ty;
    logic [15:0] it;
    logic        first;
    logic        last;
    logic [15:0] mask;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DUT 1: FIFO_DEPTH = 4
  logic        start1 = 1'b0;
  logic [15:0] rows1 = '0, cols1 = '0, inner1 = '0, off1 = '0;
  logic [1:0]  mode1 = '0;
  logic        calc1, first1, last1, busy1, done1;
  logic [15:0] tx1, ty1, it1, mask1;
  ita_tile_scheduler_if u_if1 ();

  ita_tile_scheduler #(.M(64), .N(16), .CW(16), .FIFO_DEPTH(4)) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start1),
    .rows_i        (rows1),
    .cols_i        (cols1),
    .inner_tiles_i (inner1),
    .mask_mode_i   (mode1),
    .mask_offset_i (off1),
    .op            (u_if1),
    .calc_en_o     (calc1),
    .first_inner_o (first1),
    .last_inner_o  (last1),
    .tile_x_o      (tx1),
    .tile_y_o      (ty1),
    .inner_tile_o  (it1),
    .lane_mask_o   (mask1),
    .busy_o        (busy1),
    .done_o        (done1)
  );

  // DUT 2: FIFO_DEPTH = 2 for the backpressure scenario
  logic        start2 = 1'b0;
  logic        calc2, first2, last2, busy2, done2;
  logic [15:0] tx2, ty2, it2, mask2;
  ita_tile_scheduler_if u_if2 ();

  ita_tile_scheduler #(.M(64), .N(16), .CW(16), .FIFO_DEPTH(2)) u_dut2 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start2),
    .rows_i        (16'd64),
    .cols_i        (16'd64),
    .inner_tiles_i (16'd1),
    .mask_mode_i   (2'd0),
    .mask_offset_i (16'd0),
    .op            (u_if2),
    .calc_en_o     (calc2),
    .first_inner_o (first2),
    .last_inner_o  (last2),
    .tile_x_o      (tx2),
    .tile_y_o      (ty2),
    .inner_tile_o  (it2),
    .lane_mask_o   (mask2),
    .busy_o        (busy2),
    .done_o        (done2)
  );

  beat_t exp_q[$];
  beat_t obs[0:1023];
  int    obs_n = 0;
  int    done_n = 0;
  int    done_at = -1;
  int    fires2 = 0;
  int    done2_n = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor for DUT 1
  always @(negedge clk) begin
    beat_t act, exp;
    if (calc1) begin
      act = '{tx: tx1, ty: ty1, it: it1, first: first1, last: last1, mask: mask1};
      if (obs_n < 1024) obs[obs_n] = act;
      obs_n++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected idx=%0d act=%h", obs_n - 1, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          failures++;
          $display("FAIL beat idx=%0d act=%h exp=%h", obs_n - 1, act, exp);
        end
      end
    end else begin
      checks++;
      if (mask1 !== 16'h0) begin
        failures++;
        $display("FAIL idle_mask act=%h exp=0", mask1);
      end
    end
    if (done1) begin
      done_n++;
      done_at = obs_n;
    end
  end

  always @(negedge clk) begin
    if (calc2) fires2++;
    if (done2) done2_n++;
  end

  function automatic logic [15:0] ref_mask(input longint ty, tx, b, rows, cols, mode, off);
    logic [15:0] m;
    longint row, col;
    m = '0;
    row = ty * 64 + (b % 64);
    for (int k = 0; k < 16; k++) begin
      col = tx * 64 + (b / 64) * 16 + k;
      if (row < rows && col < cols && !(mode == 1 && col > row + off) &&
          !(mode == 2 && col < row + off)) m[k] = 1'b1;
    end
    return m;
  endfunction

  task automatic start_layer(input int rows, cols, inner, mode, off);
    beat_t e;
    int nty, ntx;
    nty = (rows + 63) / 64;
    ntx = (cols + 63) / 64;
    obs_n = 0;
    done_n = 0;
    done_at = -1;
    for (int ty = 0; ty < nty; ty++)
      for (int tx = 0; tx < ntx; tx++)
        for (int it = 0; it < inner; it++)
          for (int b = 0; b < 256; b++) begin
            e.tx = 16'(tx);
            e.ty = 16'(ty);
            e.it = 16'(it);
            e.first = (it == 0);
            e.last = (it == inner - 1);
            e.mask = ref_mask(ty, tx, b, rows, cols, mode, off);
            exp_q.push_back(e);
          end
    @(negedge clk);
    rows1 = 16'(rows);
    cols1 = 16'(cols);
    inner1 = 16'(inner);
    mode1 = 2'(mode);
    off1 = 16'(off);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    // Config must be ignored once latched.
    rows1 = 16'h0005;
    cols1 = 16'hFFFF;
    inner1 = 16'h0000;
    mode1 = 2'd1;
    off1 = 16'h0003;
  endtask

  task automatic finish_layer(input string name, input int beats, input int limit);
    for (int i = 0; i < limit && done_n == 0; i++) @(negedge clk);
    check({name, "_done_seen"}, longint'(done_n != 0), 1);
    repeat (3) @(negedge clk);
    check({name, "_done_once"}, done_n, 1);
    check({name, "_done_at"}, done_at, beats);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy_end"}, busy1, 0);
  endtask

  initial begin
    u_if1.inp_valid = 1'b1;
    u_if1.weight_valid = 1'b1;
    u_if1.bias_valid = 1'b1;
    u_if1.oup_valid = 1'b1;
    u_if1.oup_ready = 1'b1;
    u_if2.inp_valid = 1'b1;
    u_if2.weight_valid = 1'b1;
    u_if2.bias_valid = 1'b1;
    u_if2.oup_valid = 1'b1;
    u_if2.oup_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy1, 0);
    check("reset_calc", calc1, 0);
    check("reset_first", first1, 0);
    check("reset_tx", tx1, 0);
    check("reset_done", done1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_inp_ready", u_if1.inp_ready, 0);

    // Full 64x64 tile, no mask
    start_layer(64, 64, 1, 0, 0);
    finish_layer("t1", 256, 400);
    check("t1_mask0", obs[0].mask, 16'hFFFF);

    // Ragged columns, two inner tiles
    start_layer(64, 70, 2, 0, 0);
    finish_layer("t2", 1024, 1200);
    check("t2_first0", obs[0].first, 1);
    check("t2_last0", obs[0].last, 0);
    check("t2_first256", obs[256].first, 0);
    check("t2_last256", obs[256].last, 1);
    check("t2_tx512", obs[512].tx, 1);
    check("t2_mask512", obs[512].mask, 16'h003F);
    check("t2_mask576", obs[576].mask, 16'h0000);
    check("t2_mask767", obs[767].mask, 16'h0000);

    // Ragged rows
    start_layer(70, 64, 1, 0, 0);
    finish_layer("t3", 512, 700);
    check("t3_mask261", obs[261].mask, 16'hFFFF);
    check("t3_mask262", obs[262].mask, 16'h0000);
    check("t3_mask326", obs[326].mask, 16'h0000);

    // Triangular masks
    start_layer(64, 64, 1, 1, 0);
    finish_layer("t4u", 256, 400);
    check("t4_upper_b5", obs[5].mask, 16'h003F);
    check("t4_upper_b69", obs[69].mask, 16'h0000);
    start_layer(64, 64, 1, 2, 0);
    finish_layer("t4l", 256, 400);
    check("t4_lower_b5", obs[5].mask, 16'hFFE0);

    // Zero dimension: immediate done, no beats
    start_layer(0, 64, 1, 0, 0);
    finish_layer("t0", 0, 10);

    // Credit backpressure on the FIFO_DEPTH=2 instance
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_stall_fires", fires2, 2);
    check("t5_stall_calc", calc2, 0);
    check("t5_stall_inp_rdy", u_if2.inp_ready, 0);
    check("t5_stall_wgt_rdy", u_if2.weight_ready, 0);
    check("t5_stall_bias_rdy", u_if2.bias_ready, 0);
    u_if2.oup_ready = 1'b1;
    @(negedge clk);
    u_if2.oup_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_one_pop", fires2, 3);
    u_if2.oup_ready = 1'b1;
    repeat (2) @(negedge clk);
    u_if2.oup_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_fire_and_pop", fires2, 5);
    u_if2.oup_ready = 1'b1;
    for (int i = 0; i < 400 && done2_n == 0; i++) @(negedge clk);
    check("t5_done", done2_n, 1);
    check("t5_total_fires", fires2, 256);

    // Asynchronous abort mid-run
    start_layer(64, 64, 1, 0, 0);
    for (int i = 0; i < 300 && obs_n < 100; i++) @(negedge clk);
    check("t6_reached_100", obs_n, 100);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", busy1, 0);
    check("t6_calc", calc1, 0);
    check("t6_mask", mask1, 0);
    check("t6_tx_ty_it", {tx1, ty1, it1}, 0);
    check("t6_first_last", {first1, last1}, 0);
    check("t6_inp_ready", u_if1.inp_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_done", done_n, 0);
    start_layer(64, 64, 1, 0, 0);
    finish_layer("t6", 256, 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
